// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback scheduler and its arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package wb_pkg;

    localparam int NUM_WB_SRC   = 3;
    localparam int WB_PREG_W    = 7;
    localparam int WB_ROB_TAG_W = 4;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_BR  = 2'd1,
        WB_LSU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [WB_PREG_W-1:0]    prd;
        logic [31:0]             data;
        logic [WB_ROB_TAG_W-1:0] rob_tag;
        logic                    has_rd;
    } wb_entry_t;

    // Age is measured as distance from the ROB head, so wrapped tags compare correctly.
    function automatic logic rob_younger(
        input logic [31:0] tag,
        input logic [31:0] ref_tag,
        input logic [31:0] head,
        input int          tag_w
    );
        logic [31:0] mask;
        logic [31:0] d_tag;
        logic [31:0] d_ref;
        mask  = (32'd1 << tag_w) - 32'd1;
        d_tag = (tag - head) & mask;
        d_ref = (ref_tag - head) & mask;
        return d_tag > d_ref;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of functional-unit result inputs, squash inputs and the CDB beat.
// Latency: n/a (wiring only).
// Backpressure: fu_ready_out per source gates each result handshake.
interface wb_arbiter_if #(
    parameter int PREG_W    = 7,
    parameter int ROB_TAG_W = 4
);
    import wb_pkg::*;

    logic [NUM_WB_SRC-1:0]                fu_valid_in;
    logic [NUM_WB_SRC-1:0]                fu_ready_out;
    logic [NUM_WB_SRC-1:0][PREG_W-1:0]    fu_prd_in;
    logic [NUM_WB_SRC-1:0][31:0]          fu_data_in;
    logic [NUM_WB_SRC-1:0][ROB_TAG_W-1:0] fu_rob_tag_in;
    logic [NUM_WB_SRC-1:0]                fu_has_rd_in;

    logic [ROB_TAG_W-1:0]                 rob_head;
    logic                                 mispredict;
    logic [ROB_TAG_W-1:0]                 mispredict_tag;

    logic                                 cdb_valid;
    logic [PREG_W-1:0]                    cdb_prd;
    logic [31:0]                          cdb_data;
    logic [ROB_TAG_W-1:0]                 cdb_rob_tag;
    logic                                 cdb_has_rd;
    logic [1:0]                           cdb_src;
    logic [15:0]                          stall_cnt;

    modport master (
        output fu_valid_in, fu_prd_in, fu_data_in, fu_rob_tag_in, fu_has_rd_in,
        output rob_head, mispredict, mispredict_tag,
        input  fu_ready_out,
        input  cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_has_rd, cdb_src, stall_cnt
    );

    modport slave (
        input  fu_valid_in, fu_prd_in, fu_data_in, fu_rob_tag_in, fu_has_rd_in,
        input  rob_head, mispredict, mispredict_tag,
        output fu_ready_out,
        output cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_has_rd, cdb_src, stall_cnt
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter3.sv
// Three-way round-robin picker: first requester at or after ptr, wrapping 2->0.
// Latency: combinational.
// Backpressure: none; grant is zero when no request is present.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    logic [2:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (grant == 3'b000 && req[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback scheduler: one holding slot per FU, round-robin onto a registered CDB beat.
// Latency: result accepted at edge E is on the CDB after edge E+1.
// Backpressure: a held slot drops fu_ready_out until it wins the CDB (or is refilled on its win).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int PREG_W    = 7,
    parameter int ROB_TAG_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  wb
);

    typedef struct packed {
        logic [PREG_W-1:0]    prd;
        logic [31:0]          data;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 has_rd;
    } slot_t;

    slot_t [NUM_WB_SRC-1:0] hold;
    logic  [NUM_WB_SRC-1:0] hold_valid;
    logic  [NUM_WB_SRC-1:0] squash_hold;
    logic  [NUM_WB_SRC-1:0] squash_in;
    logic  [NUM_WB_SRC-1:0] req;
    logic  [NUM_WB_SRC-1:0] grant;
    logic  [NUM_WB_SRC-1:0] accept;
    logic  [1:0]            rr_ptr;
    logic  [1:0]            win_idx;
    wb_src_e                winner;
    logic                   multi_held;

    always_comb begin
        squash_hold = '0;
        squash_in   = '0;
        for (int i = 0; i < NUM_WB_SRC; i++) begin
            squash_hold[i] = wb.mispredict &
                rob_younger(32'(hold[i].rob_tag), 32'(wb.mispredict_tag),
                            32'(wb.rob_head), ROB_TAG_W);
            squash_in[i]   = wb.mispredict &
                rob_younger(32'(wb.fu_rob_tag_in[i]), 32'(wb.mispredict_tag),
                            32'(wb.rob_head), ROB_TAG_W);
        end
    end

    // Grant depends only on registered slots, so ready never loops back through fu_valid_in.
    assign req = hold_valid & ~squash_hold;

    rr_arbiter3 u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        winner = WB_ALU;
        if (grant[1]) begin
            winner = WB_BR;
        end else if (grant[2]) begin
            winner = WB_LSU;
        end
    end

    assign win_idx         = winner;
    assign wb.fu_ready_out = ~hold_valid | grant;
    // Squashed arrivals still complete their handshake; they are simply not stored.
    assign accept          = wb.fu_valid_in & wb.fu_ready_out & ~squash_in;
    assign multi_held      = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid     <= '0;
            hold           <= '0;
            rr_ptr         <= 2'd0;
            wb.cdb_valid   <= 1'b0;
            wb.cdb_prd     <= '0;
            wb.cdb_data    <= '0;
            wb.cdb_rob_tag <= '0;
            wb.cdb_has_rd  <= 1'b0;
            wb.cdb_src     <= 2'd0;
            wb.stall_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_WB_SRC; i++) begin
                if (accept[i]) begin
                    hold_valid[i]     <= 1'b1;
                    hold[i].prd       <= wb.fu_prd_in[i];
                    hold[i].data      <= wb.fu_data_in[i];
                    hold[i].rob_tag   <= wb.fu_rob_tag_in[i];
                    hold[i].has_rd    <= wb.fu_has_rd_in[i];
                end else if (grant[i] || squash_hold[i]) begin
                    hold_valid[i]     <= 1'b0;
                end
            end

            if (grant != '0) begin
                wb.cdb_valid   <= 1'b1;
                wb.cdb_prd     <= hold[win_idx].prd;
                wb.cdb_data    <= hold[win_idx].data;
                wb.cdb_rob_tag <= hold[win_idx].rob_tag;
                wb.cdb_has_rd  <= hold[win_idx].has_rd;
                wb.cdb_src     <= win_idx;
                unique case (winner)
                    WB_ALU:  rr_ptr <= 2'd1;
                    WB_BR:   rr_ptr <= 2'd2;
                    default: rr_ptr <= 2'd0;
                endcase
            end else begin
                wb.cdb_valid   <= 1'b0;
            end

            if (multi_held && wb.stall_cnt != 16'hFFFF) begin
                wb.stall_cnt <= wb.stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences, then random traffic vs a slot-level model.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bench-side input registers, copied onto the bus by drive().
    logic        i_rst;
    logic [2:0]  i_vld;
    logic [2:0]  i_hasrd;
    logic [6:0]  i_prd  [3];
    logic [31:0] i_data [3];
    logic [3:0]  i_tag  [3];
    logic [3:0]  i_head;
    logic        i_mp;
    logic [3:0]  i_mptag;

    task automatic drive();
        reset              = i_rst;
        bus.fu_valid_in    = i_vld;
        bus.fu_has_rd_in   = i_hasrd;
        bus.rob_head       = i_head;
        bus.mispredict     = i_mp;
        bus.mispredict_tag = i_mptag;
        for (int i = 0; i < 3; i++) begin
            bus.fu_prd_in[i]     = i_prd[i];
            bus.fu_data_in[i]    = i_data[i];
            bus.fu_rob_tag_in[i] = i_tag[i];
        end
    endtask

    function automatic logic [6:0] tprd(input int s, input logic [3:0] t);
        return {1'b0, 2'(s), t};
    endfunction

    function automatic logic [31:0] tdata(input int s, input logic [3:0] t);
        return 32'hA000_0000 | (32'(s) << 8) | 32'(t);
    endfunction

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic [3:0]  t0, t1, t2;
        logic [3:0]  head;
        logic        mp;
        logic [3:0]  mptag;
        logic        chk_rdy;
        logic [2:0]  e_rdy;
        logic        e_cv;
        logic [1:0]  e_src;
        logic [3:0]  e_tag;
        logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [2:0] vld, input logic [3:0] t0, t1, t2,
        input logic [3:0] head, input logic mp, input logic [3:0] mptag,
        input logic chk_rdy, input logic [2:0] e_rdy, input logic e_cv,
        input logic [1:0] e_src, input logic [3:0] e_tag, input logic [15:0] e_stall);
        vec_t v;
        v.rst = rst; v.vld = vld; v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.head = head; v.mp = mp; v.mptag = mptag;
        v.chk_rdy = chk_rdy; v.e_rdy = e_rdy; v.e_cv = e_cv;
        v.e_src = e_src; v.e_tag = e_tag; v.e_stall = e_stall;
        return v;
    endfunction

    vec_t vt [23];

    // Reference model: slot contents and CDB beat derived directly from the scheduling rules.
    bit          m_hv   [3];
    logic [6:0]  m_prd  [3];
    logic [31:0] m_data [3];
    int          m_tag  [3];
    logic        m_hr   [3];
    int          m_ptr;
    bit          m_cv;
    logic [6:0]  m_cprd;
    logic [31:0] m_cdata;
    int          m_ctag;
    logic        m_chr;
    int          m_csrc;
    int          m_stall;

    function automatic bit m_younger(input int t, input int b, input int h);
        int dt;
        int db;
        dt = (t - h + 16) % 16;
        db = (b - h + 16) % 16;
        return dt > db;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hv[i] = 0; m_prd[i] = '0; m_data[i] = '0; m_tag[i] = 0; m_hr[i] = 1'b0;
        end
        m_ptr = 0; m_cv = 0; m_cprd = '0; m_cdata = '0; m_ctag = 0; m_chr = 1'b0;
        m_csrc = 0; m_stall = 0;
    endtask

    int          win;
    bit          elig [3];
    logic [2:0]  m_rdy;

    task automatic model_pre();
        int idx;
        win = -1;
        for (int i = 0; i < 3; i++)
            elig[i] = m_hv[i] && !(i_mp && m_younger(m_tag[i], int'(i_mptag), int'(i_head)));
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (win < 0 && elig[idx]) win = idx;
        end
        for (int i = 0; i < 3; i++) m_rdy[i] = !m_hv[i] || (win == i);
    endtask

    task automatic model_edge();
        int n_el;
        if (i_rst) begin
            model_reset();
            return;
        end
        n_el = 0;
        for (int i = 0; i < 3; i++) if (elig[i]) n_el++;
        if (n_el >= 2 && m_stall < 65535) m_stall++;
        if (win >= 0) begin
            m_cv = 1; m_cprd = m_prd[win]; m_cdata = m_data[win]; m_ctag = m_tag[win];
            m_chr = m_hr[win]; m_csrc = win; m_ptr = (win + 1) % 3;
        end else begin
            m_cv = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (i_vld[i] && m_rdy[i] && !(i_mp && m_younger(int'(i_tag[i]), int'(i_mptag), int'(i_head)))) begin
                m_hv[i] = 1; m_prd[i] = i_prd[i]; m_data[i] = i_data[i];
                m_tag[i] = int'(i_tag[i]); m_hr[i] = i_hasrd[i];
            end else if (win == i || (m_hv[i] && !elig[i])) begin
                m_hv[i] = 0;
            end
        end
    endtask

    initial begin
        vt[0]  = mk(1, 3'b000, 0, 0, 0,   0, 0, 0,   0, 3'b000, 0, 0, 0,  0);
        vt[1]  = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 0, 0, 0,  0);
        vt[2]  = mk(0, 3'b111, 1, 2, 3,   0, 0, 0,   1, 3'b111, 0, 0, 0,  0);
        vt[3]  = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b001, 1, 0, 1,  1);
        vt[4]  = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b011, 1, 1, 2,  2);
        vt[5]  = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 1, 2, 3,  2);
        vt[6]  = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[7]  = mk(0, 3'b001, 4, 0, 0,   0, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[8]  = mk(0, 3'b001, 5, 0, 0,   0, 0, 0,   1, 3'b111, 1, 0, 4,  2);
        vt[9]  = mk(0, 3'b001, 6, 0, 0,   0, 0, 0,   1, 3'b111, 1, 0, 5,  2);
        vt[10] = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 1, 0, 6,  2);
        vt[11] = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[12] = mk(0, 3'b101, 0, 0, 13, 12, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[13] = mk(0, 3'b000, 0, 0, 0,  12, 1, 15,  1, 3'b110, 1, 2, 13, 2);
        vt[14] = mk(0, 3'b000, 0, 0, 0,  12, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[15] = mk(0, 3'b010, 0, 15, 0, 14, 1, 15,  1, 3'b111, 0, 0, 0,  2);
        vt[16] = mk(0, 3'b000, 0, 0, 0,  14, 0, 0,   1, 3'b111, 1, 1, 15, 2);
        vt[17] = mk(0, 3'b001, 2, 0, 0,  14, 1, 15,  1, 3'b111, 0, 0, 0,  2);
        vt[18] = mk(0, 3'b000, 0, 0, 0,  14, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[19] = mk(0, 3'b111, 7, 8, 9,   0, 0, 0,   1, 3'b111, 0, 0, 0,  2);
        vt[20] = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b100, 1, 2, 9,  3);
        vt[21] = mk(1, 3'b111, 1, 1, 1,   0, 0, 0,   1, 3'b101, 0, 0, 0,  0);
        vt[22] = mk(0, 3'b000, 0, 0, 0,   0, 0, 0,   1, 3'b111, 0, 0, 0,  0);

        i_hasrd = 3'b111;
        for (int r = 0; r < 23; r++) begin
            i_rst = vt[r].rst; i_vld = vt[r].vld; i_head = vt[r].head;
            i_mp = vt[r].mp; i_mptag = vt[r].mptag;
            i_tag[0] = vt[r].t0; i_tag[1] = vt[r].t1; i_tag[2] = vt[r].t2;
            for (int i = 0; i < 3; i++) begin
                i_prd[i]  = tprd(i, i_tag[i]);
                i_data[i] = tdata(i, i_tag[i]);
            end
            drive();
            @(negedge clk);
            if (vt[r].chk_rdy) check($sformatf("vec%0d_ready", r), 32'(bus.fu_ready_out), 32'(vt[r].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_cdb_valid", r), 32'(bus.cdb_valid), 32'(vt[r].e_cv));
            if (vt[r].e_cv) begin
                check($sformatf("vec%0d_cdb_src", r), 32'(bus.cdb_src), 32'(vt[r].e_src));
                check($sformatf("vec%0d_cdb_tag", r), 32'(bus.cdb_rob_tag), 32'(vt[r].e_tag));
                check($sformatf("vec%0d_cdb_prd", r), 32'(bus.cdb_prd), 32'(tprd(int'(vt[r].e_src), vt[r].e_tag)));
                check($sformatf("vec%0d_cdb_data", r), bus.cdb_data, tdata(int'(vt[r].e_src), vt[r].e_tag));
            end
            check($sformatf("vec%0d_stall_cnt", r), 32'(bus.stall_cnt), 32'(vt[r].e_stall));
        end

        // Single ALU result: accepted at edge 1, broadcast after edge 2.
        i_rst = 0; i_vld = 3'b001; i_head = 0; i_mp = 0; i_mptag = 0; i_hasrd = 3'b111;
        i_tag[0] = 4'd3; i_prd[0] = 7'd5; i_data[0] = 32'hDEAD_BEEF;
        drive();
        @(negedge clk);
        check("alu_single_ready_e1", 32'(bus.fu_ready_out), 32'h7);
        @(posedge clk);
        #1;
        check("alu_single_cdb_valid_e1", 32'(bus.cdb_valid), 32'h0);
        i_vld = 3'b000;
        drive();
        @(negedge clk);
        check("alu_single_ready_e2", 32'(bus.fu_ready_out), 32'h7);
        @(posedge clk);
        #1;
        check("alu_single_cdb_valid", 32'(bus.cdb_valid), 32'h1);
        check("alu_single_cdb_prd", 32'(bus.cdb_prd), 32'd5);
        check("alu_single_cdb_data", bus.cdb_data, 32'hDEAD_BEEF);
        check("alu_single_cdb_src", 32'(bus.cdb_src), 32'd0);
        check("alu_single_cdb_tag", 32'(bus.cdb_rob_tag), 32'd3);
        check("alu_single_cdb_has_rd", 32'(bus.cdb_has_rd), 32'd1);
        @(posedge clk);
        #1;
        check("alu_single_cdb_drops", 32'(bus.cdb_valid), 32'h0);

        // Random traffic against the model, starting from a reset cycle.
        i_rst = 1; i_vld = '0;
        drive();
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            i_rst   = ($urandom_range(0, 199) == 0);
            i_vld   = 3'($urandom);
            i_hasrd = 3'($urandom);
            i_head  = 4'($urandom);
            i_mp    = ($urandom_range(0, 5) == 0);
            i_mptag = 4'($urandom);
            for (int i = 0; i < 3; i++) begin
                i_prd[i]  = 7'($urandom);
                i_data[i] = $urandom;
                i_tag[i]  = 4'($urandom);
            end
            drive();
            model_pre();
            @(negedge clk);
            check("rand_ready", 32'(bus.fu_ready_out), 32'(m_rdy));
            @(posedge clk);
            model_edge();
            #1;
            check("rand_cdb_valid", 32'(bus.cdb_valid), 32'(m_cv));
            check("rand_cdb_prd", 32'(bus.cdb_prd), 32'(m_cprd));
            check("rand_cdb_data", bus.cdb_data, m_cdata);
            check("rand_cdb_tag", 32'(bus.cdb_rob_tag), 32'(m_ctag));
            check("rand_cdb_has_rd", 32'(bus.cdb_has_rd), 32'(m_chr));
            check("rand_cdb_src", 32'(bus.cdb_src), 32'(m_csrc));
            check("rand_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
